// File: rtl/country_car_detector.sv
// -----------------------------------------------------------------------------
// country_car_detector
//
// Conditions the raw country-road loop sensor into the caroncountry request
// consumed by signal_control. The raw loop is synchronized, debounced, and
// turned into arrival/departure events that drive a saturating waiting-car
// counter.
//
// Ports:
//   clk           single clock, rising edge
//   clr           synchronous active-high reset
//   loop_raw      asynchronous loop detector, 1 = metal present
//   csig          country signal from signal_control (00 RED, 01 YELLOW,
//                 10 GREEN, 11 treated as not GREEN)
//   caroncountry  1 while at least one car is queued
//   car_count     number of queued cars (saturates at 2^CNT_W-1)
//   overflow      sticky: an arrival was seen while car_count was saturated
//
// Build option:
//   STUCK_TIMEOUT_EN  when defined, compiles in a timer that clears the queue
//                     after TIMEOUT_CYCLES GREEN cycles without a departure.
// -----------------------------------------------------------------------------
module country_car_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             loop_raw,
    input  logic [1:0]       csig,
    output logic             caroncountry,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow
);

    localparam logic [1:0]       CSIG_GREEN = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [7:0]       DEB_TC     = 8'(DEBOUNCE_CYCLES);

    logic             sync_1;
    logic             sync_2;
    logic             deb_level;
    logic [7:0]       stab_cnt;
    logic [7:0]       stab_cnt_inc;
    logic             deb_toggle;
    logic             arrive;
    logic             depart;
    logic             green;
    logic             timeout_hit;
    logic [CNT_W-1:0] count_next;
    logic             overflow_next;

    // Two-flop synchronizer for the asynchronous loop input
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= loop_raw;
            sync_2 <= sync_1;
        end
    end

    // Stability counter runs only while the synchronized sample disagrees with
    // the debounced level; the level flips on the cycle the count is reached.
    assign stab_cnt_inc = stab_cnt + 8'd1;
    assign deb_toggle   = (sync_2 != deb_level) && (stab_cnt_inc == DEB_TC);

    always_ff @(posedge clk) begin
        if (clr) begin
            deb_level <= 1'b0;
            stab_cnt  <= 8'd0;
        end else if (sync_2 != deb_level) begin
            if (deb_toggle) begin
                deb_level <= ~deb_level;
                stab_cnt  <= 8'd0;
            end else begin
                stab_cnt  <= stab_cnt_inc;
            end
        end else begin
            stab_cnt <= 8'd0;
        end
    end

    assign green  = (csig == CSIG_GREEN);
    assign arrive = deb_toggle & ~deb_level;
    assign depart = deb_toggle &  deb_level & green;

`ifdef STUCK_TIMEOUT_EN
    logic [15:0] timer;
    logic [15:0] timer_inc;

    assign timer_inc   = timer + 16'd1;
    // A departure restarts the wait, so it can never coincide with a timeout.
    assign timeout_hit = green && (car_count != '0) && !depart &&
                         (timer_inc == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (clr) begin
            timer <= 16'd0;
        end else if (!green || (car_count == '0) || depart || timeout_hit) begin
            timer <= 16'd0;
        end else begin
            timer <= timer_inc;
        end
    end
`else
    // No timer: the queue moves only on arrivals and departures.
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        count_next    = car_count;
        overflow_next = overflow;
        if (arrive) begin
            if (car_count == CNT_MAX) begin
                overflow_next = 1'b1;
            end else begin
                count_next = car_count + CNT_W'(1);
            end
        end else if (depart) begin
            if (car_count != '0) begin
                count_next = car_count - CNT_W'(1);
            end
        end
        // A car arriving on the timeout edge is the only one left waiting.
        if (timeout_hit) begin
            count_next = arrive ? CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            car_count <= '0;
            overflow  <= 1'b0;
        end else begin
            car_count <= count_next;
            overflow  <= overflow_next;
        end
    end

    assign caroncountry = (car_count != '0);

endmodule

// File: tb/tb_country_car_detector.sv
// -----------------------------------------------------------------------------
// tb_country_car_detector
//
// Directed scenarios plus randomized loop/csig/clr traffic, each cycle compared
// against a behavioural model built from the detector's rules: the loop is seen
// two edges late, a level is accepted after DEB identical samples differing
// from the current level, and rises/falls move a saturating counter.
// Honors STUCK_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_country_car_detector;

    localparam int DEB  = 4;
    localparam int TO   = 64;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clr;
    logic          loop_raw;
    logic [1:0]    csig;
    logic          caroncountry;
    logic [CW-1:0] car_count;
    logic          overflow;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    bit m_d1, m_d2, m_deb, m_last, m_ovf;
    int m_run, m_count, m_timer;

    country_car_detector #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .loop_raw    (loop_raw),
        .csig        (csig),
        .caroncountry(caroncountry),
        .car_count   (car_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One rising edge of the reference behaviour, using the inputs held at it.
    task automatic model_edge();
        bit s, arr, dep, to_hit, grn;
        if (clr) begin
            m_d1 = 0; m_d2 = 0; m_deb = 0; m_last = 0; m_ovf = 0;
            m_run = 0; m_count = 0; m_timer = 0;
            return;
        end
        s   = m_d2;
        grn = (csig == 2'b10);
        if (s == m_last) m_run++;
        else m_run = 1;
        m_last = s;
        arr = 0;
        dep = 0;
        if (s != m_deb && m_run >= DEB) begin
            if (!m_deb) arr = 1;
            else        dep = grn;
            m_deb = s;
        end
        to_hit = 0;
`ifdef STUCK_TIMEOUT_EN
        if (!grn || m_count == 0 || dep) m_timer = 0;
        else if (m_timer + 1 == TO) begin
            to_hit  = 1;
            m_timer = 0;
        end else m_timer++;
`endif
        if (arr) begin
            if (m_count == MAXC) m_ovf = 1;
            else m_count++;
        end else if (dep && m_count > 0) begin
            m_count--;
        end
        if (to_hit) m_count = arr ? 1 : 0;
        m_d2 = m_d1;
        m_d1 = loop_raw;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("car_count",    int'(car_count),    m_count);
        check("caroncountry", int'(caroncountry), int'(m_count != 0));
        check("overflow",     int'(overflow),     int'(m_ovf));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic car_pulse(input int hi, input int lo);
        loop_raw = 1'b1;
        ticks(hi);
        loop_raw = 1'b0;
        ticks(lo);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int hold;
        clr      = 1'b1;
        loop_raw = 1'b0;
        csig     = 2'b00;
        ticks(2);
        check("rst_count",    int'(car_count),    0);
        check("rst_caron",    int'(caroncountry), 0);
        check("rst_overflow", int'(overflow),     0);
        clr = 1'b0;
        tick();

        // Clean step: counted on the sixth edge that sees it
        loop_raw = 1'b1;
        ticks(5);
        check("step_edge5_count", int'(car_count), 0);
        tick();
        check("step_edge6_count", int'(car_count),    1);
        check("step_edge6_caron", int'(caroncountry), 1);
        loop_raw = 1'b0;
        ticks(10);
        check("step_red_fall_kept", int'(car_count), 1);
        do_clr();

        // Glitch shorter than the debounce window
        car_pulse(3, 12);
        check("glitch_count", int'(car_count),    0);
        check("glitch_caron", int'(caroncountry), 0);

        // Three cars under RED; falls under RED are ignored
        csig = 2'b00;
        repeat (3) car_pulse(8, 8);
        check("red_three_count", int'(car_count), 3);
        // With a single loop every exit is preceded by its own arrival
        csig = 2'b10;
        for (int i = 0; i < 3; i++) begin
            loop_raw = 1'b1;
            ticks(8);
            check("green_rise_count", int'(car_count), 4);
            loop_raw = 1'b0;
            ticks(8);
            check("green_exit_count", int'(car_count), 3);
        end
        csig = 2'b11;
        car_pulse(8, 8);
        check("csig11_not_green", int'(car_count), 4);
        csig = 2'b00;
        do_clr();

        // Saturation and sticky overflow
        repeat (17) car_pulse(6, 6);
        check("sat_count",    int'(car_count), 15);
        check("sat_overflow", int'(overflow),  1);
        loop_raw = 1'b1;
        ticks(8);
        check("sat_rise_count", int'(car_count), 15);
        csig     = 2'b10;
        loop_raw = 1'b0;
        ticks(8);
        check("sat_exit_count",    int'(car_count), 14);
        check("sat_exit_overflow", int'(overflow),  1);
        csig = 2'b00;
        do_clr();
        check("clr_overflow", int'(overflow), 0);

        // Stuck GREEN with two queued cars
        repeat (2) car_pulse(6, 6);
        check("stuck_start", int'(car_count), 2);
        csig = 2'b10;
        ticks(63);
        check("stuck_green63", int'(car_count), 2);
        tick();
`ifdef STUCK_TIMEOUT_EN
        check("stuck_green64", int'(car_count), 0);
`else
        check("stuck_green64", int'(car_count), 2);
`endif
        csig = 2'b00;
        do_clr();

        // clr mid-debounce with five cars queued
        repeat (5) car_pulse(6, 6);
        check("mid_clr_start", int'(car_count), 5);
        loop_raw = 1'b1;
        ticks(3);
        clr      = 1'b1;
        loop_raw = 1'b0;
        tick();
        check("mid_clr_count",    int'(car_count),    0);
        check("mid_clr_caron",    int'(caroncountry), 0);
        check("mid_clr_overflow", int'(overflow),     0);
        clr = 1'b0;
        ticks(20);
        check("mid_clr_no_spurious", int'(car_count), 0);

        // Loop held through clr: exactly one arrival afterwards
        loop_raw = 1'b1;
        clr      = 1'b1;
        ticks(2);
        clr = 1'b0;
        ticks(20);
        check("held_loop_one_arrival", int'(car_count), 1);
        loop_raw = 1'b0;
        ticks(10);
        do_clr();

        // Randomized traffic
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                loop_raw = 1'($urandom_range(0, 1));
                hold     = int'($urandom_range(1, 9));
            end
            hold--;
            if ($urandom_range(0, 15) == 0) csig = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 299) == 0);
            tick();
        end
        clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
